// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO arbiter and its round-robin picker.
package pio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
    localparam logic        PIO_RW_WRITE = 1'b1;
    localparam logic        PIO_RW_READ  = 1'b0;

    // Index width that stays legal (>=1) even for a single-entry vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr+1 (mod N).
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = IDX_W'(cand);
            end
        end
        if (any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/pio_arbiter.sv
// Round-robin sharing of one single-outstanding PIO target among NUM_REQ requesters.
// Define PIO_ARB_TIMEOUT_EN to enable the read-timeout guard and error completion.
module pio_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      req_err,
    output logic                      pio_cmd_vld,
    output logic                      pio_rw,
    output logic [ADDR_W-1:0]         pio_addr,
    output logic [DATA_W-1:0]         pio_data_w,
    input  logic [DATA_W-1:0]         pio_data_r,
    input  logic                      pio_rd_vld
);

    localparam int IDX_W = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || RD_TIMEOUT < 2) begin : g_param_check
        $error("pio_arbiter: NUM_REQ must be 2..8 and RD_TIMEOUT >= 2");
    end

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     ptr_reg;
    logic [NUM_REQ-1:0]   grant_oh_reg;
    logic [DATA_W-1:0]    rdata_reg;
    logic                 err_reg;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 grant_now;
    logic                 timeout_hit;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req_vld),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign grant_now = (state_reg == IDLE) && arb_any;

`ifdef PIO_ARB_TIMEOUT_EN
    localparam int             TMR_W    = idx_width(RD_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RD_TIMEOUT - 2);

    logic [TMR_W-1:0] timer_reg;

    // Timer counts finished WAIT_RD cycles; expiry fires on the cycle whose increment
    // would reach RD_TIMEOUT-1, so the error ack lands RD_TIMEOUT cycles after ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_reg <= '0;
        end else if (state_reg == ISSUE) begin
            timer_reg <= '0;
        end else if (state_reg == WAIT_RD) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == WAIT_RD) && !pio_rd_vld && (timer_reg == TMR_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (arb_any) state_next = ISSUE;
            ISSUE:   state_next = (pio_rw == PIO_RW_READ) ? WAIT_RD : RESP;
            WAIT_RD: if (pio_rd_vld || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Completion is only presented during RESP so idle outputs stay at zero.
    always_comb begin
        req_ack   = '0;
        req_rdata = '0;
        req_err   = 1'b0;
        if (state_reg == RESP) begin
            req_ack   = grant_oh_reg;
            req_rdata = rdata_reg;
            req_err   = err_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg      <= IDX_W'(NUM_REQ - 1);
            grant_oh_reg <= '0;
            pio_cmd_vld  <= 1'b0;
            pio_rw       <= 1'b0;
            pio_addr     <= '0;
            pio_data_w   <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            pio_cmd_vld <= grant_now;
            if (grant_now) begin
                ptr_reg      <= arb_idx;
                grant_oh_reg <= arb_grant;
                pio_rw       <= req_rw[arb_idx];
                pio_addr     <= addr_arr[arb_idx];
                pio_data_w   <= wdata_arr[arb_idx];
                rdata_reg    <= '0;
                err_reg      <= 1'b0;
            end
            if (state_reg == WAIT_RD) begin
                if (pio_rd_vld) begin
                    rdata_reg <= pio_data_r;
                    err_reg   <= 1'b0;
                end else if (timeout_hit) begin
                    rdata_reg <= DATA_W'(TIMEOUT_DATA);
                    err_reg   <= 1'b1;
                end
            end
        end
    end

endmodule
